// File: rtl/i2s_serializer.sv
// I2S transmitter: divides i_clk into BCK, frames left/right 18-bit samples MSB-first
// with one-BCK delay, and strobes o_latch before each frame. Optional mute: I2S_MUTE_EN.
module i2s_serializer #(
  parameter int CLK_DIV   = 2,
  parameter int SLOT_BITS = 32,
  parameter int DATA_BITS = 18
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [DATA_BITS-1:0] i_left,
  input  logic [DATA_BITS-1:0] i_right,
`ifdef I2S_MUTE_EN
  input  logic                 i_mute,
`endif
  output logic                 o_latch,
  output logic                 o_bck,
  output logic                 o_lrck,
  output logic                 o_sdata
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int BW = $clog2(2 * SLOT_BITS);
  localparam int PW = $clog2(SLOT_BITS);

  logic [DW-1:0]        div;
  logic [BW-1:0]        bit_cnt;
  logic [BW-1:0]        bit_nxt;
  logic [PW-1:0]        pos;
  logic                 wrap;
  logic                 tick_fall;
  logic                 sdata_nxt;
  logic [DATA_BITS-1:0] sh_l;
  logic [DATA_BITS-1:0] sh_r;
  logic [DATA_BITS-1:0] sh_sel;
  logic [DATA_BITS-1:0] load_l;
  logic [DATA_BITS-1:0] load_r;

  assign wrap      = (div == DW'(CLK_DIV - 1));
  assign tick_fall = wrap & o_bck;
  // Slot count is a power of two, so the natural wrap of the adder gives mod 2*SLOT_BITS.
  assign bit_nxt   = bit_cnt + BW'(1);
  assign pos       = bit_nxt[PW-1:0];
  assign sh_sel    = bit_nxt[BW-1] ? sh_r : sh_l;

`ifdef I2S_MUTE_EN
  assign load_l = i_mute ? '0 : i_left;
  assign load_r = i_mute ? '0 : i_right;
`else
  assign load_l = i_left;
  assign load_r = i_right;
`endif

  // Slot position p=1 carries the MSB; p=0 and p>DATA_BITS are zero padding.
  always_comb begin
    sdata_nxt = 1'b0;
    for (int i = 0; i < DATA_BITS; i++) begin
      if (int'(pos) == DATA_BITS - i) sdata_nxt = sh_sel[i];
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      div     <= '0;
      o_bck   <= 1'b0;
      bit_cnt <= BW'(2 * SLOT_BITS - 1);
      o_lrck  <= 1'b1;
      o_sdata <= 1'b0;
      o_latch <= 1'b0;
      sh_l    <= '0;
      sh_r    <= '0;
    end else begin
      if (wrap) begin
        div   <= '0;
        o_bck <= ~o_bck;
      end else begin
        div <= div + DW'(1);
      end
      o_latch <= tick_fall && (bit_nxt == '1);
      if (tick_fall) begin
        bit_cnt <= bit_nxt;
        o_lrck  <= bit_nxt[BW-1];
        o_sdata <= sdata_nxt;
        // Both channels captured together so a frame never mixes sample pairs.
        if (bit_nxt == '0) begin
          sh_l <= load_l;
          sh_r <= load_r;
        end
      end
    end
  end

endmodule

// File: tb/tb_i2s_serializer.sv
// Self-checking bench for i2s_serializer: expected per-BCK bits are queued per frame
// from the loaded sample pair and popped as the serializer emits them.
module tb_i2s_serializer;
  localparam int CLK_DIV   = 2;
  localparam int SLOT_BITS = 32;
  localparam int DATA_BITS = 18;

  logic                 i_clk = 1'b0;
  logic                 i_rst = 1'b1;
  logic [DATA_BITS-1:0] i_left = '0;
  logic [DATA_BITS-1:0] i_right = '0;
`ifdef I2S_MUTE_EN
  logic                 i_mute = 1'b0;
`endif
  logic o_latch, o_bck, o_lrck, o_sdata;

  int errors = 0;
  int checks = 0;
  logic [2:0] exp_q[$];

  i2s_serializer #(.CLK_DIV(CLK_DIV), .SLOT_BITS(SLOT_BITS), .DATA_BITS(DATA_BITS)) dut (
    .i_clk(i_clk),
    .i_rst(i_rst),
    .i_left(i_left),
    .i_right(i_right),
`ifdef I2S_MUTE_EN
    .i_mute(i_mute),
`endif
    .o_latch(o_latch),
    .o_bck(o_bck),
    .o_lrck(o_lrck),
    .o_sdata(o_sdata)
  );

  always #5 i_clk = ~i_clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic exp_bit(input int n, input logic [DATA_BITS-1:0] l,
                                   input logic [DATA_BITS-1:0] r);
    int p;
    p = n % SLOT_BITS;
    if (p >= 1 && p <= DATA_BITS) return (n < SLOT_BITS) ? l[DATA_BITS-p] : r[DATA_BITS-p];
    return 1'b0;
  endfunction

  // Starts right after a load edge; ends right after the next load edge (256 clocks).
  // Expected {bck, lrck, sdata} is compared mid-bit, when BCK is high.
  task automatic run_frame(input string name, input logic [DATA_BITS-1:0] l,
                           input logic [DATA_BITS-1:0] r, input int chg_at,
                           input logic [DATA_BITS-1:0] nl, input logic [DATA_BITS-1:0] nr);
    logic [2:0] exp;
    int latch_cnt;
    int latch_at;
    for (int n = 0; n < 2 * SLOT_BITS; n++)
      exp_q.push_back({1'b1, n >= SLOT_BITS, exp_bit(n, l, r)});
    latch_cnt = 0;
    latch_at  = -1;
    for (int c = 1; c <= 4 * CLK_DIV * SLOT_BITS; c++) begin
      @(posedge i_clk); #1;
      if (c == chg_at) begin
        i_left  = nl;
        i_right = nr;
      end
      if (o_latch === 1'b1) begin
        latch_cnt++;
        latch_at = c;
      end
      if (c % 4 == 2) begin
        exp = exp_q.pop_front();
        checks++;
        if ({o_bck, o_lrck, o_sdata} !== exp) begin
          errors++;
          $display("FAIL %s bit n=%0d: bck/lrck/sdata got %b expected %b",
                   name, (c - 2) / 4, {o_bck, o_lrck, o_sdata}, exp);
        end
      end
      if (c % 4 == 0) begin
        checks++;
        if (o_bck !== 1'b0) begin
          errors++;
          $display("FAIL %s bck_low c=%0d: got %b expected 0", name, c, o_bck);
        end
      end
    end
    checks++;
    if (latch_cnt != 1 || latch_at != 252) begin
      errors++;
      $display("FAIL %s latch: got %0d pulses last at clock %0d, expected 1 pulse at clock 252",
               name, latch_cnt, latch_at);
    end
  endtask

  // Releases reset and checks the first four edges; ends right after the first load edge.
  task automatic release_startup(input string name);
    logic [3:0] exp;
    @(negedge i_clk);
    i_rst = 1'b0;
    for (int e = 1; e <= 4; e++) begin
      @(posedge i_clk); #1;
      exp = (e == 4) ? 4'b0000 : {(e == 2 || e == 3), 3'b100};
      checks++;
      if ({o_bck, o_lrck, o_sdata, o_latch} !== exp) begin
        errors++;
        $display("FAIL %s startup edge %0d: bck/lrck/sdata/latch got %b expected %b",
                 name, e, {o_bck, o_lrck, o_sdata, o_latch}, exp);
      end
    end
  endtask

  task automatic test_reset();
    i_rst   = 1'b1;
    i_left  = 18'h2AAAA;
    i_right = 18'h15555;
    repeat (3) @(posedge i_clk);
    #1;
    checks++;
    if ({o_bck, o_lrck, o_sdata, o_latch} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_values: got %b expected 0100", {o_bck, o_lrck, o_sdata, o_latch});
    end
    release_startup("reset");
  endtask

  task automatic test_pattern();
    run_frame("pattern0", 18'h2AAAA, 18'h15555, 0, '0, '0);
    run_frame("pattern1", 18'h2AAAA, 18'h15555, 200, 18'h3FFFF, 18'h0F0F0);
  endtask

  task automatic test_hold();
    run_frame("hold", 18'h3FFFF, 18'h0F0F0, 40, 18'h00000, 18'h0F0F0);
    run_frame("hold_next", 18'h00000, 18'h0F0F0, 0, '0, '0);
  endtask

  task automatic test_back_to_back();
    logic [DATA_BITS-1:0] l, r, nl, nr;
    l = 18'h00000;
    r = 18'h0F0F0;
    for (int f = 0; f < 3; f++) begin
      nl = DATA_BITS'($urandom);
      nr = DATA_BITS'($urandom);
      run_frame("b2b", l, r, int'($urandom_range(1, 255)), nl, nr);
      l = nl;
      r = nr;
    end
    run_frame("b2b_last", l, r, 100, 18'h2AAAA, 18'h15555);
  endtask

  task automatic test_reset_midframe();
    repeat (150) @(posedge i_clk);
    #2;
    i_rst = 1'b1;
    #1;
    checks++;
    if ({o_bck, o_lrck, o_sdata, o_latch} !== 4'b0100) begin
      errors++;
      $display("FAIL async_reset: got %b expected 0100", {o_bck, o_lrck, o_sdata, o_latch});
    end
    @(posedge i_clk); #1;
    checks++;
    if ({o_bck, o_lrck, o_sdata, o_latch} !== 4'b0100) begin
      errors++;
      $display("FAIL reset_hold: got %b expected 0100", {o_bck, o_lrck, o_sdata, o_latch});
    end
    release_startup("restart");
    run_frame("restart", 18'h2AAAA, 18'h15555, 0, '0, '0);
  endtask

`ifdef I2S_MUTE_EN
  task automatic test_mute();
    fork
      run_frame("mute_pre", 18'h2AAAA, 18'h15555, 100, 18'h3FFFF, 18'h3FFFF);
      begin
        repeat (200) @(posedge i_clk);
        #2 i_mute = 1'b1;
      end
    join
    fork
      run_frame("muted", 18'h00000, 18'h00000, 0, '0, '0);
      begin
        repeat (10) @(posedge i_clk);
        #2 i_mute = 1'b0;
      end
    join
    fork
      run_frame("mute_mid", 18'h3FFFF, 18'h3FFFF, 0, '0, '0);
      begin
        repeat (40) @(posedge i_clk);
        #2 i_mute = 1'b1;
        repeat (160) @(posedge i_clk);
        #2 i_mute = 1'b0;
      end
    join
  endtask
`endif

  initial begin
    test_reset();
    test_pattern();
    test_hold();
    test_back_to_back();
    test_reset_midframe();
`ifdef I2S_MUTE_EN
    test_mute();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
